// File: rtl/stream_xbar_packet_net.sv
// stream_xbar_packet_net
// Packet crossbar. Each output locks onto one source that an external arbiter
// picked for it. It forwards that source's beats into a small per-output FIFO
// and unlocks when the last beat of the packet is accepted.
module stream_xbar_packet_net #(
   parameter  int T_DATA_WIDTH = 8,
   parameter  int S_DATA_COUNT = 2,
   parameter  int M_DATA_COUNT = 3,
   parameter  int FIFO_DEPTH   = 2,
   localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
   localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
   input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
   input  logic [S_DATA_COUNT-1:0]                   s_last_i,
   input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
   output logic [S_DATA_COUNT-1:0]                   s_ready_o,
   output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
   output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] m_id_o,
   output logic [M_DATA_COUNT-1:0]                   m_last_o,
   output logic [M_DATA_COUNT-1:0]                   m_valid_o,
   input  logic [M_DATA_COUNT-1:0]                   m_ready_i,
   input  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_i,
   input  logic [M_DATA_COUNT-1:0]                   grant_valid_i,
   output logic [M_DATA_COUNT-1:0]                   grant_ack_o,
   output logic [M_DATA_COUNT-1:0]                   release_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W = T_DATA_WIDTH + T_ID___WIDTH + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                  state_q   [M_DATA_COUNT];
   logic [T_ID___WIDTH-1:0] lock_id_q [M_DATA_COUNT];
   logic [PTR_W-1:0]        wr_ptr_q  [M_DATA_COUNT];
   logic [PTR_W-1:0]        rd_ptr_q  [M_DATA_COUNT];
   logic [CNT_W-1:0]        count_q   [M_DATA_COUNT];
   logic [ENT_W-1:0]        mem_q     [M_DATA_COUNT][FIFO_DEPTH];

   logic [M_DATA_COUNT-1:0] lock_req;
   logic [M_DATA_COUNT-1:0] busy_rdy;
   logic [M_DATA_COUNT-1:0] push;
   logic [M_DATA_COUNT-1:0] pop;
   logic [ENT_W-1:0]        push_ent  [M_DATA_COUNT];
   logic [ENT_W-1:0]        head_ent  [M_DATA_COUNT];

   // Lock decision, per-source ready, and FIFO push/pop strobes for every output.
   // Ready is built from state, FIFO fill and destination only, never from valid.
   always_comb begin
      lock_req  = '0;
      busy_rdy  = '0;
      push      = '0;
      pop       = '0;
      s_ready_o = '0;
      release_o = '0;
      for (int j = 0; j < M_DATA_COUNT; j++) begin
         push_ent[j] = '0;
         if (!rst_i && (state_q[j] == IDLE) && grant_valid_i[j] &&
             (int'(grant_i[j]) < S_DATA_COUNT)) begin
            lock_req[j] = s_valid_i[grant_i[j]] &&
                          (s_dest_i[grant_i[j]] == T_DEST_WIDTH'(j));
         end
         if (state_q[j] == BUSY) begin
            busy_rdy[j] = (s_dest_i[lock_id_q[j]] == T_DEST_WIDTH'(j)) &&
                          (count_q[j] != FULL_CNT);
         end
         s_ready_o[lock_id_q[j]] = s_ready_o[lock_id_q[j]] | busy_rdy[j];
         push[j]      = busy_rdy[j] & s_valid_i[lock_id_q[j]];
         release_o[j] = push[j] & s_last_i[lock_id_q[j]];
         push_ent[j]  = {s_data_i[lock_id_q[j]], lock_id_q[j], s_last_i[lock_id_q[j]]};
         pop[j]       = (count_q[j] != '0) & m_ready_i[j];
      end
   end

   assign grant_ack_o = lock_req;

   // Present the FIFO head; outputs are forced to zero whenever the FIFO is empty.
   always_comb begin
      m_valid_o = '0;
      m_data_o  = '0;
      m_id_o    = '0;
      m_last_o  = '0;
      for (int j = 0; j < M_DATA_COUNT; j++) begin
         head_ent[j]  = mem_q[j][rd_ptr_q[j]];
         m_valid_o[j] = (count_q[j] != '0);
         if (m_valid_o[j]) begin
            m_data_o[j] = head_ent[j][ENT_W-1 -: T_DATA_WIDTH];
            m_id_o[j]   = head_ent[j][T_ID___WIDTH:1];
            m_last_o[j] = head_ent[j][0];
         end
      end
   end

   // Per-output lock FSM: IDLE -> BUSY on lock, BUSY -> IDLE on the accepted last beat.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int j = 0; j < M_DATA_COUNT; j++) begin
            state_q[j]   <= IDLE;
            lock_id_q[j] <= '0;
         end
      end else begin
         for (int j = 0; j < M_DATA_COUNT; j++) begin
            case (state_q[j])
               IDLE: begin
                  if (lock_req[j]) begin
                     state_q[j]   <= BUSY;
                     lock_id_q[j] <= grant_i[j];
                  end
               end
               BUSY: begin
                  if (release_o[j]) state_q[j] <= IDLE;
               end
               default: state_q[j] <= IDLE;
            endcase
         end
      end
   end

   // FIFO pointers and fill count; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int j = 0; j < M_DATA_COUNT; j++) begin
            wr_ptr_q[j] <= '0;
            rd_ptr_q[j] <= '0;
            count_q[j]  <= '0;
         end
      end else begin
         for (int j = 0; j < M_DATA_COUNT; j++) begin
            if (push[j]) wr_ptr_q[j] <= wr_ptr_q[j] + PTR_W'(1);
            if (pop[j])  rd_ptr_q[j] <= rd_ptr_q[j] + PTR_W'(1);
            case ({push[j], pop[j]})
               2'b10:   count_q[j] <= count_q[j] + CNT_W'(1);
               2'b01:   count_q[j] <= count_q[j] - CNT_W'(1);
               default: count_q[j] <= count_q[j];
            endcase
         end
      end
   end

   // FIFO storage; contents are meaningful only where the count says so, so no reset.
   always_ff @(posedge clk_i) begin
      for (int j = 0; j < M_DATA_COUNT; j++) begin
         if (push[j]) mem_q[j][wr_ptr_q[j]] <= push_ent[j];
      end
   end

endmodule
